// File: rtl/imem_loader_ctrl_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The master drives bytes in and observes the memory writes. The slave is the controller.
interface imem_loader_ctrl_if #(
    parameter int AW = 8
);
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/imem_loader_ctrl.sv
// Fills instruction memory from a big-endian byte stream and holds the CPU while loading.
// Outside a load, the CPU fetch address passes straight through to the memory read port.
module imem_loader_ctrl #(
    parameter int DEPTH         = 256,
    parameter int AW            = 8,
    parameter int HOLD_AT_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    imem_loader_ctrl_if.slave   bus,
    input  logic                load_start,
    input  logic [AW:0]         load_words,
    input  logic [31:0]         cpu_addr,
    output logic [AW-1:0]       mem_raddr,
    output logic                cpu_hold,
    output logic                load_busy,
    output logic                load_done
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic [AW:0]   remaining;
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_cnt;
    logic [31:0]   asm_word;
    logic          loaded;
    logic          byte_ready, mem_we;
    logic          unused_addr;

    assign mem_raddr   = cpu_addr[AW-1:0];
    assign unused_addr = ^cpu_addr[31:AW];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Outputs decode from state only, so byte_ready never depends on byte_valid.
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (load_start)
                    state_nxt = (load_words != '0) ? RECV : DONE;
            end
            RECV: begin
                byte_ready = 1'b1;
                load_busy  = 1'b1;
                if (bus.byte_valid && byte_cnt == 2'd3)
                    state_nxt = WRITE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                load_busy = 1'b1;
                state_nxt = (remaining == (AW+1)'(1)) ? DONE : RECV;
            end
            DONE: begin
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            asm_word  <= '0;
            loaded    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        remaining <= (load_words > DEPTH_W) ? DEPTH_W : load_words;
                        word_idx  <= '0;
                        byte_cnt  <= '0;
                    end
                end
                RECV: begin
                    if (bus.byte_valid) begin
                        asm_word <= {asm_word[23:0], bus.byte_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    // A full-depth load wraps word_idx back to 0.
                    word_idx  <= word_idx + AW'(1);
                    remaining <= remaining - (AW+1)'(1);
                end
                DONE: loaded <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.mem_we     = mem_we;
    assign bus.mem_waddr  = word_idx;
    assign bus.mem_wdata  = asm_word;
    assign cpu_hold       = (state != IDLE) || ((HOLD_AT_RESET != 0) && !loaded);
endmodule
